// File: rtl/opb_addr_decode_hs.sv
// OPB address decoder/router: per-slave base/size windows, fixed-latency or ACK-handshake slaves,
// bus-error responses with capture. Define OPB_DEC_TIMEOUT_EN to enable the handshake timeout.
module opb_addr_decode_hs #(
  parameter int                    NUM_SLV     = 4,
  parameter int                    AW          = 32,
  parameter int                    DW          = 32,
  parameter logic [NUM_SLV*AW-1:0] SLV_BASE    = {32'h300, 32'h200, 32'h100, 32'h0},
  parameter logic [NUM_SLV*AW-1:0] SLV_SIZE    = {4{32'h100}},
  parameter logic [NUM_SLV-1:0]    ACK_MASK    = 4'b1100,
  parameter int                    TIMEOUT     = 16,
  parameter int                    TW          = 8,
  parameter logic [15:0]           ERR_CNT_MAX = 16'hFFFF
) (
  input  logic                  OPB_CLK,
  input  logic                  OPB_RST_N,
  input  logic                  OPB_RE,
  input  logic                  OPB_WE,
  input  logic [AW-1:0]         OPB_ADDR,
  output logic [DW-1:0]         OPB_DO,
  output logic                  OPB_ACK,
  output logic                  OPB_ERR,
  output logic [NUM_SLV-1:0]    SLV_RE,
  output logic [NUM_SLV-1:0]    SLV_WE,
  input  logic [NUM_SLV*DW-1:0] SLV_RDATA,
  input  logic [NUM_SLV-1:0]    SLV_ACK,
  output logic [AW-1:0]         ERR_ADDR,
  output logic [1:0]            ERR_CODE,
  output logic [15:0]           ERR_CNT,
  output logic [1:0]            dbg_state
);
  localparam int IW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_ERR = 2'd2} state_t;

  state_t          state, state_n;
  logic [IW-1:0]   sel, win_idx;
  logic            rd, forced;
  logic [NUM_SLV-1:0] hit, win_oh;
  logic            any_hit, accept, ack_c, err_c, to_err;
  logic [1:0]      code_n;
  logic [AW-1:0]   cap_addr;

  // Window bounds are widened by one bit so base+size never wraps.
  function automatic logic in_window(input logic [AW-1:0] a, input int i);
    logic [AW:0] lo, hi;
    lo = {1'b0, SLV_BASE[i*AW +: AW]};
    hi = lo + {1'b0, SLV_SIZE[i*AW +: AW]};
    return ({1'b0, a} >= lo) && ({1'b0, a} < hi);
  endfunction

  always_comb begin
    hit     = '0;
    win_idx = '0;
    for (int i = 0; i < NUM_SLV; i++) hit[i] = in_window(OPB_ADDR, i);
    for (int i = NUM_SLV - 1; i >= 0; i--) if (hit[i]) win_idx = IW'(i);
  end

  assign win_oh  = hit & (~hit + 1'b1);
  assign any_hit = |hit;
  assign accept  = OPB_RST_N && (state == S_IDLE) && (OPB_RE ^ OPB_WE) && any_hit;
  assign SLV_RE  = (accept && OPB_RE) ? win_oh : '0;
  assign SLV_WE  = (accept && OPB_WE) ? win_oh : '0;

`ifdef OPB_DEC_TIMEOUT_EN
  logic [TW-1:0] timer;
  logic [AW-1:0] addr_q;

  // Address is kept so a timeout reports the original strobe address.
  always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
    if (!OPB_RST_N) begin
      timer  <= '0;
      addr_q <= '0;
    end else if (accept) begin
      timer  <= '0;
      addr_q <= OPB_ADDR;
    end else if (state == S_WAIT && !ack_c) begin
      timer  <= timer + 1'b1;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT > 0) ^ (TW > 0);
`endif

  always_comb begin
    state_n  = state;
    ack_c    = 1'b0;
    err_c    = 1'b0;
    to_err   = 1'b0;
    code_n   = ERR_CODE;
    cap_addr = OPB_ADDR;
    case (state)
      S_IDLE: begin
        if (OPB_RE && OPB_WE) begin
          to_err = 1'b1;
          code_n = 2'b11;
        end else if (OPB_RE || OPB_WE) begin
          if (any_hit) state_n = S_WAIT;
          else begin
            to_err = 1'b1;
            code_n = 2'b01;
          end
        end
      end
      S_WAIT: begin
        ack_c = forced | SLV_ACK[sel];
        if (ack_c) state_n = S_IDLE;
`ifdef OPB_DEC_TIMEOUT_EN
        else if (timer == TW'(TIMEOUT - 1)) begin
          to_err   = 1'b1;
          code_n   = 2'b10;
          cap_addr = addr_q;
        end
`endif
      end
      S_ERR: begin
        ack_c   = 1'b1;
        err_c   = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    if (to_err) state_n = S_ERR;
  end

  always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
    if (!OPB_RST_N) begin
      state    <= S_IDLE;
      sel      <= '0;
      rd       <= 1'b0;
      forced   <= 1'b0;
      ERR_ADDR <= '0;
      ERR_CODE <= '0;
      ERR_CNT  <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        sel    <= win_idx;
        rd     <= OPB_RE;
        forced <= ~ACK_MASK[win_idx];
      end
      if (to_err) begin
        ERR_ADDR <= cap_addr;
        ERR_CODE <= code_n;
        if (ERR_CNT != ERR_CNT_MAX) ERR_CNT <= ERR_CNT + 16'd1;
      end
    end
  end

  assign OPB_ACK   = ack_c;
  assign OPB_ERR   = err_c;
  assign OPB_DO    = (ack_c && rd && !err_c) ? SLV_RDATA[int'(sel)*DW +: DW] : '0;
  assign dbg_state = state;
endmodule

// File: tb/tb_opb_addr_decode_hs.sv
// Bench for opb_addr_decode_hs: directed plan items plus random transactions against a
// window-table reference model; error counter ceiling is lowered to keep the run short.
module tb_opb_addr_decode_hs;
  localparam int          TIMEOUT = 16;
  localparam logic [15:0] CNT_MAX = 16'd200;
  localparam logic [3:0]  MASK    = 4'b1100;
`ifdef OPB_DEC_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk = 1'b0, rst_n = 1'b0;
  logic         opb_re = 1'b0, opb_we = 1'b0;
  logic [31:0]  opb_addr = '0;
  logic [31:0]  opb_do;
  logic         opb_ack, opb_err;
  logic [3:0]   slv_re, slv_we, slv_ack = '0;
  logic [127:0] slv_rdata = '0;
  logic [31:0]  err_addr;
  logic [1:0]   err_code, dbg_state;
  logic [15:0]  err_cnt;

  int checks = 0, errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] m_err_addr = '0;
  logic [1:0]  m_err_code = '0;
  logic [15:0] m_err_cnt  = '0;
  longint      win_base[4] = '{64'h0, 64'h100, 64'h200, 64'h300};
  longint      win_size[4] = '{64'h100, 64'h100, 64'h100, 64'h100};

  opb_addr_decode_hs #(.TIMEOUT(TIMEOUT), .ERR_CNT_MAX(CNT_MAX)) dut (
    .OPB_CLK(clk), .OPB_RST_N(rst_n), .OPB_RE(opb_re), .OPB_WE(opb_we),
    .OPB_ADDR(opb_addr), .OPB_DO(opb_do), .OPB_ACK(opb_ack), .OPB_ERR(opb_err),
    .SLV_RE(slv_re), .SLV_WE(slv_we), .SLV_RDATA(slv_rdata), .SLV_ACK(slv_ack),
    .ERR_ADDR(err_addr), .ERR_CODE(err_code), .ERR_CNT(err_cnt), .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Lowest-numbered window containing the address, or -1.
  function automatic int ref_decode(input logic [31:0] a);
    for (int i = 0; i < 4; i++)
      if (longint'(a) >= win_base[i] && longint'(a) < win_base[i] + win_size[i]) return i;
    return -1;
  endfunction

  task automatic chk_err_regs(input string tag);
    chk({tag, "_err_addr"}, err_addr, m_err_addr);
    chk({tag, "_err_code"}, err_code, m_err_code);
    chk({tag, "_err_cnt"},  err_cnt,  m_err_cnt);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"}, opb_ack, 0);
    chk({tag, "_err"}, opb_err, 0);
    chk({tag, "_do"}, opb_do, 0);
    chk({tag, "_slv_re"}, slv_re, 0);
    chk({tag, "_slv_we"}, slv_we, 0);
    chk({tag, "_state"}, dbg_state, 0);
    chk_err_regs(tag);
  endtask

  // One transfer: strobe at T, handshake slave raises SLV_ACK at T+d.
  task automatic do_txn(input logic [31:0] a, input logic re, input logic we,
                        input int d, input bit reissue);
    int idx, ack_k, last_k;
    bit exp_err;
    logic [1:0] code;
    logic [3:0] exp_str;
    idx = ref_decode(a);
    for (int i = 0; i < 4; i++) slv_rdata[i*32 +: 32] = $urandom;
    exp_err = 1'b0;
    code    = 2'b00;
    if (re && we) begin exp_err = 1'b1; code = 2'b11; ack_k = 1; end
    else if (idx < 0) begin exp_err = 1'b1; code = 2'b01; ack_k = 1; end
    else if (!MASK[idx]) ack_k = 1;
    else if (d <= TIMEOUT || !TO_EN) ack_k = d;
    else begin exp_err = 1'b1; code = 2'b10; ack_k = TIMEOUT + 1; end
    last_k = (exp_err && code == 2'b10) ? ack_k + 3 : ack_k;
    exp_q.push_back((!exp_err && re) ? slv_rdata[idx*32 +: 32] : 32'h0);
    exp_str = (exp_err || idx < 0) ? 4'b0000 : 4'b0001 << idx;

    @(posedge clk); #1;
    opb_re = re; opb_we = we; opb_addr = a; slv_ack = '0;
    @(negedge clk);
    chk("slv_re_T", slv_re, re ? exp_str : 4'b0);
    chk("slv_we_T", slv_we, we ? exp_str : 4'b0);
    chk("ack_T", opb_ack, 0);

    for (int k = 1; k <= last_k; k++) begin
      @(posedge clk); #1;
      opb_we = 1'b0;
      opb_re = reissue && (k == 1);
      opb_addr = reissue ? 32'h104 : $urandom;
      slv_ack = (idx >= 0 && MASK[idx] && k == d) ? (4'b0001 << idx) : 4'b0000;
      @(negedge clk);
      chk("slv_re_wait", slv_re, 0);
      if (k == ack_k) begin
        if (exp_err) begin
          m_err_addr = a;
          m_err_code = code;
          if (m_err_cnt != CNT_MAX) m_err_cnt++;
        end
        chk("ack", opb_ack, 1);
        chk("err", opb_err, exp_err);
        chk("do", opb_do, exp_q.pop_front());
        chk_err_regs("cap");
      end else begin
        chk("no_ack", opb_ack, 0);
      end
    end
  endtask

  initial begin
    int op, dly;
    logic [31:0] a;
    // reset
    #1; chk_all_zero("reset");
    @(negedge clk); rst_n = 1'b1;

    // Directed plan items
    do_txn(32'h104, 1, 0, 0, 0);                 // legacy read
    do_txn(32'h210, 0, 1, 3, 0);                 // handshake write, ack at T+3
    do_txn(32'h400, 1, 0, 0, 0);                 // unmapped
    do_txn(32'h300, 1, 0, TO_EN ? 18 : 30, 0);   // timeout / indefinite wait
    do_txn(32'h000, 1, 1, 0, 0);                 // RE & WE together
    do_txn(32'h308, 1, 0, 2, 1);                 // re-issued strobe during WAIT ignored
    do_txn(32'h30C, 1, 0, TIMEOUT, 0);           // ack on the expiry cycle wins
    do_txn(32'h0FF, 1, 0, 0, 0);                 // window edges
    do_txn(32'h100, 0, 1, 0, 0);
    do_txn(32'h3FF, 0, 1, 1, 0);
    do_txn(32'hFFFF_FFFF, 0, 1, 0, 0);

    // Reset while a handshake read is waiting
    @(posedge clk); #1; opb_re = 1'b1; opb_addr = 32'h304;
    @(posedge clk); #1; opb_re = 1'b1; opb_addr = 32'h104;
    @(posedge clk); #1; rst_n = 1'b0;
    m_err_addr = '0; m_err_code = '0; m_err_cnt = '0;
    #1; chk_all_zero("rst_wait");
    @(negedge clk); opb_re = 1'b0; rst_n = 1'b1;

    // Random traffic
    for (int n = 0; n < 80; n++) begin
      op  = $urandom_range(0, 9);
      a   = $urandom_range(0, 32'h4FF);
      dly = $urandom_range(1, 6);
      do_txn(a, op <= 5, op == 0 || op > 5, dly, ($urandom_range(0, 3) == 0));
    end

    // Drive the error counter to its ceiling
    for (int n = 0; n < int'(CNT_MAX) + 5; n++)
      do_txn($urandom_range(32'h400, 32'hFFFF), 1, 0, 0, 0);
    chk("cnt_sat", err_cnt, CNT_MAX);

    @(posedge clk); #1; opb_re = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/opb_addr_decode_hs.md
Name: opb_addr_decode_hs

Overview:
- Parametrised OPB address decoder/router for NUM_SLV peripherals.
- Per-slave base/size and per-slave choice of fixed 1-cycle read latency or ACK handshake.
- Adds bus-error response for unmapped addresses, illegal strobes and handshake timeouts, with an error capture/status interface.
- Sits between the OPB master and all peripheral register blocks.

Parameters:
- NUM_SLV, 4, number of slave ports.
- AW, 32, address width.
- DW, 32, data width.
- SLV_BASE, {32'h300,32'h200,32'h100,32'h0}, flat NUM_SLV*AW vector; slice i is the base of slave i.
- SLV_SIZE, {4{32'h100}}, flat NUM_SLV*AW vector; slice i is the byte span of slave i.
- ACK_MASK, 4'b1100, bit i=1: slave i uses SLV_ACK handshake; bit i=0: fixed 1-cycle response.
- TIMEOUT, 16, maximum WAIT cycles before a timeout error (≥1).
- TW, 8, timeout counter width.

Ports:
- OPB_CLK  in  1  clock.
- OPB_RST_N  in  1  asynchronous active-low reset.
- OPB_RE  in  1  read strobe, single cycle.
- OPB_WE  in  1  write strobe, single cycle.
- OPB_ADDR  in  AW  address, valid with strobe.
- OPB_DO  out  DW  read data, valid while OPB_ACK=1.
- OPB_ACK  out  1  transfer complete, 1-cycle pulse.
- OPB_ERR  out  1  error qualifier, only high with OPB_ACK.
- SLV_RE  out  NUM_SLV  per-slave read strobe.
- SLV_WE  out  NUM_SLV  per-slave write strobe.
- SLV_RDATA  in  NUM_SLV*DW  per-slave read data.
- SLV_ACK  in  NUM_SLV  per-slave ready (bits used only where ACK_MASK=1).
- ERR_ADDR  out  AW  address of the last error.
- ERR_CODE  out  2  last error: 01 unmapped, 10 timeout, 11 RE&WE together.
- ERR_CNT  out  16  saturating error count.

Behaviour:
- Reset (async, OPB_RST_N=0):
  - state=IDLE; all outputs 0; ERR_ADDR/ERR_CODE/ERR_CNT cleared.
  - Reset mid-transaction abandons it with no ACK.
- Decode: hit[i] = OPB_ADDR>=BASE_i && OPB_ADDR<BASE_i+SIZE_i, computed AW+1 bits wide so there is no wrap. Multiple hits: lowest index wins.
- Strobes are accepted only in IDLE; strobes in any other state are ignored (master must wait for ACK).
- SLV_RE/SLV_WE: combinational = accepted strobe & winning hit, a one-cycle pulse in the strobe cycle (cycle T).
- FSM states IDLE, WAIT, ERR:
  - IDLE, RE xor WE, hit i:
    - Latch index and direction.
    - ACK_MASK[i]=0: go to WAIT with ack forced, so OPB_ACK=1 at T+1.
    - ACK_MASK[i]=1: go to WAIT and clear the timer.
  - IDLE, RE&WE both high: no slave strobe; go to ERR, code 11.
  - IDLE, no hit: go to ERR, code 01.
  - WAIT:
    - OPB_ACK = forced | SLV_ACK[sel], combinational; on ACK return to IDLE.
    - Otherwise the timer increments. At count==TIMEOUT-1 without ACK, go to ERR with code 10 (first ERR cycle = T+1+TIMEOUT).
    - SLV_ACK arriving in the same cycle as expiry wins: normal completion.
  - ERR: one cycle with OPB_ACK=1, OPB_ERR=1, OPB_DO=0; then IDLE.
- Late SLV_ACK after a timeout is ignored.
- OPB_DO = SLV_RDATA[sel] when OPB_ACK & read & !OPB_ERR; otherwise 0. Write ACKs drive OPB_DO=0.
- Error capture, on entry to ERR: ERR_ADDR<=OPB_ADDR of the offending strobe, ERR_CODE updated, ERR_CNT+1 saturating at 16'hFFFF.
- Back-to-back: a new strobe is accepted the cycle after OPB_ACK (state IDLE).

Optional Feature:
- Macro OPB_DEC_TIMEOUT_EN.
- Defined: timeout counter and code 10 exist as described above.
- Undefined:
  - No counter logic; WAIT holds until SLV_ACK indefinitely.
  - ERR_CODE never takes the value 10.
  - TIMEOUT and TW are unused.

Test Plan:
- Read 0x104 (slave 1, legacy), SLV_RDATA[1]=32'hA5A5_0001 -> SLV_RE=4'b0010 at T; OPB_ACK=1, OPB_DO=32'hA5A5_0001, OPB_ERR=0 at T+1.
- Write 0x210 (slave 2, handshake), SLV_ACK[2] at T+3 -> SLV_WE=4'b0100 at T only; OPB_ACK at T+3; OPB_DO=0.
- Read 0x400 (unmapped) -> no SLV strobe; OPB_ACK&OPB_ERR at T+1; ERR_ADDR=0x400, ERR_CODE=01, ERR_CNT=1.
- Read 0x300 (slave 3), SLV_ACK held low -> OPB_ACK&OPB_ERR at T+17 (TIMEOUT=16), ERR_CODE=10; a late SLV_ACK[3] produces no ACK. With the macro undefined -> no ACK until SLV_ACK.
- OPB_RE&OPB_WE at 0x000 -> ERR_CODE=11, no SLV strobe. A strobe re-issued during WAIT is ignored. OPB_RST_N low during WAIT -> all outputs 0 immediately, state IDLE.
- Force 0x10000 errors -> ERR_CNT saturates at 16'hFFFF.
